// File: rtl/mem_if_pkg.sv
// Shared types and constants for the L1 block memory interface.
package mem_if_pkg;
  localparam int BLOCK_W     = 256;
  localparam int WORD_W      = 32;
  localparam int OFFSET_BITS = 5;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  typedef enum logic {REQ_I, REQ_D} req_t;
  typedef enum logic {OP_READ, OP_WRITE} op_t;
endpackage

// File: rtl/mem_arbiter.sv
// Grant selection between the I-side and D-side block requesters.
// MEM_RR_ARB_EN: round-robin between sides; otherwise fixed D-write > D-read > I-read.
module mem_arbiter
  import mem_if_pkg::*;
(
`ifdef MEM_RR_ARB_EN
  input  logic clk,
  input  logic reset,
  input  logic accept,
`endif
  input  logic i_req,
  input  logic d_rd,
  input  logic d_wr,
  output logic grant_valid,
  output req_t grant_req,
  output op_t  grant_op
);
  logic d_any;
  op_t  d_op;

  assign d_any       = d_rd | d_wr;
  assign grant_valid = i_req | d_any;
  assign d_op        = d_wr ? OP_WRITE : OP_READ;

`ifdef MEM_RR_ARB_EN
  // Side granted most recently; it loses the next simultaneous conflict.
  req_t last;

  always_ff @(posedge clk) begin
    if (reset) begin
      last <= REQ_I;
    end else if (accept) begin
      last <= grant_req;
    end
  end

  always_comb begin
    grant_req = REQ_I;
    if (d_any && (!i_req || last == REQ_I)) begin
      grant_req = REQ_D;
    end
  end
`else
  always_comb begin
    grant_req = REQ_I;
    if (d_any) begin
      grant_req = REQ_D;
    end
  end
`endif

  assign grant_op = (grant_req == REQ_D) ? d_op : OP_READ;
endmodule

// File: rtl/block_mem_responder.sv
// Main-memory model for the L1 caches: block store, arbitration and fixed latency.
// Build option MEM_RR_ARB_EN selects round-robin arbitration between I and D sides.
module block_mem_responder
  import mem_if_pkg::*;
#(
  parameter int DEPTH_BLOCKS = 1024,
  parameter int READ_LAT     = 10,
  parameter int WRITE_LAT    = 10
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [31:0]        i_addr,
  input  logic               i_blk_read,
  output logic [BLOCK_W-1:0] i_rdata,
  output logic               i_read_valid,
  input  logic [31:0]        d_addr,
  input  logic               d_blk_read,
  input  logic               d_blk_write,
  input  logic [BLOCK_W-1:0] d_wdata,
  output logic [BLOCK_W-1:0] d_rdata,
  output logic               d_read_valid,
  output logic               d_write_valid,
  output logic               busy
);
  localparam int IDX_W   = $clog2(DEPTH_BLOCKS);
  localparam int LAT_MAX = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);

  logic [BLOCK_W-1:0] mem [DEPTH_BLOCKS];

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   idx_q;
  req_t               req_q;
  op_t                op_q;
  logic [BLOCK_W-1:0] wdata_q;

  logic [IDX_W-1:0]   i_idx;
  logic [IDX_W-1:0]   d_idx;
  logic               grant_valid;
  req_t               grant_req;
  op_t                grant_op;
  logic               complete;
  logic               unused_addr_bits;

  // Upper address bits are dropped so addresses wrap modulo the store size.
  assign i_idx = i_addr[OFFSET_BITS+IDX_W-1:OFFSET_BITS];
  assign d_idx = d_addr[OFFSET_BITS+IDX_W-1:OFFSET_BITS];
  assign unused_addr_bits = ^{i_addr[31:OFFSET_BITS+IDX_W], i_addr[OFFSET_BITS-1:0],
                              d_addr[31:OFFSET_BITS+IDX_W], d_addr[OFFSET_BITS-1:0]};

  assign complete = (state == WAIT) && (cnt == '0);

`ifdef MEM_RR_ARB_EN
  logic accept;
  assign accept = (state == IDLE) && grant_valid;
`endif

  mem_arbiter u_arb (
`ifdef MEM_RR_ARB_EN
    .clk         (CLK),
    .reset       (RESET),
    .accept      (accept),
`endif
    .i_req       (i_blk_read),
    .d_rd        (d_blk_read),
    .d_wr        (d_blk_write),
    .grant_valid (grant_valid),
    .grant_req   (grant_req),
    .grant_op    (grant_op)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= IDLE;
      cnt           <= '0;
      idx_q         <= '0;
      req_q         <= REQ_I;
      op_q          <= OP_READ;
      wdata_q       <= '0;
      i_rdata       <= '0;
      d_rdata       <= '0;
      i_read_valid  <= 1'b0;
      d_read_valid  <= 1'b0;
      d_write_valid <= 1'b0;
      busy          <= 1'b0;
    end else begin
      i_read_valid  <= 1'b0;
      d_read_valid  <= 1'b0;
      d_write_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            req_q <= grant_req;
            op_q  <= grant_op;
            idx_q <= (grant_req == REQ_D) ? d_idx : i_idx;
            if (grant_op == OP_WRITE) begin
              wdata_q <= d_wdata;
            end
            cnt   <= (grant_op == OP_WRITE) ? CNT_W'(WRITE_LAT - 1) : CNT_W'(READ_LAT - 1);
            busy  <= 1'b1;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state <= DONE;
            if (op_q == OP_WRITE) begin
              d_write_valid <= 1'b1;
            end else if (req_q == REQ_D) begin
              d_read_valid <= 1'b1;
              d_rdata      <= mem[idx_q];
            end else begin
              i_read_valid <= 1'b1;
              i_rdata      <= mem[idx_q];
            end
          end
        end
        // Recovery cycle: the requester is still dropping its level request.
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Backing store is not reset; a reset cancels any pending commit.
  always_ff @(posedge CLK) begin
    if (!RESET && complete && op_q == OP_WRITE) begin
      mem[idx_q] <= wdata_q;
    end
  end
endmodule

// File: tb/tb_block_mem_responder.sv
// Directed bench for block_mem_responder: table-driven ops plus arbitration,
// reset-abort, held-request and unit-latency sequences.
module tb_block_mem_responder;
  logic         CLK = 1'b0;
  logic         RESET;
  logic [31:0]  i_addr;
  logic         i_blk_read;
  logic [31:0]  d_addr;
  logic         d_blk_read;
  logic         d_blk_write;
  logic [255:0] d_wdata;

  logic [255:0] i_rdata, d_rdata, f_i_rdata, f_d_rdata;
  logic         i_read_valid, d_read_valid, d_write_valid, busy;
  logic         f_i_read_valid, f_d_read_valid, f_d_write_valid, f_busy;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  block_mem_responder #(.DEPTH_BLOCKS(1024), .READ_LAT(10), .WRITE_LAT(10)) dut (
    .CLK(CLK), .RESET(RESET),
    .i_addr(i_addr), .i_blk_read(i_blk_read), .i_rdata(i_rdata), .i_read_valid(i_read_valid),
    .d_addr(d_addr), .d_blk_read(d_blk_read), .d_blk_write(d_blk_write), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_read_valid(d_read_valid), .d_write_valid(d_write_valid), .busy(busy)
  );

  // Unit-latency instance; shares all inputs, only checked in its own phase.
  block_mem_responder #(.DEPTH_BLOCKS(1024), .READ_LAT(1), .WRITE_LAT(1)) dut_fast (
    .CLK(CLK), .RESET(RESET),
    .i_addr(i_addr), .i_blk_read(i_blk_read), .i_rdata(f_i_rdata), .i_read_valid(f_i_read_valid),
    .d_addr(d_addr), .d_blk_read(d_blk_read), .d_blk_write(d_blk_write), .d_wdata(d_wdata),
    .d_rdata(f_d_rdata), .d_read_valid(f_d_read_valid), .d_write_valid(f_d_write_valid), .busy(f_busy)
  );

  typedef struct {
    string        name;
    int           kind;   // 0 = D write, 1 = D read, 2 = I read
    logic [31:0]  addr;
    logic [255:0] wdata;
    logic [255:0] exp_data;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [255:0] pat(input logic [31:0] base);
    logic [255:0] p;
    for (int k = 0; k < 8; k++) p[32*k +: 32] = base + 32'(k);
    return p;
  endfunction

  function automatic logic get_valid(input int kind, input bit fast);
    case (kind)
      0:       return fast ? f_d_write_valid : d_write_valid;
      1:       return fast ? f_d_read_valid  : d_read_valid;
      default: return fast ? f_i_read_valid  : i_read_valid;
    endcase
  endfunction

  function automatic logic [255:0] get_rdata(input int kind, input bit fast);
    if (kind == 2) return fast ? f_i_rdata : i_rdata;
    return fast ? f_d_rdata : d_rdata;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Counts edges until the selected valid is seen (bounded).
  task automatic wait_valid(input int kind, input bit fast, output int cyc);
    cyc = 0;
    do begin
      @(posedge CLK); #1;
      cyc++;
    end while (!get_valid(kind, fast) && cyc < 60);
  endtask

  task automatic drive(input int kind, input logic [31:0] addr, input logic [255:0] wdata);
    case (kind)
      0: begin d_addr = addr; d_wdata = wdata; d_blk_write = 1'b1; end
      1: begin d_addr = addr; d_blk_read = 1'b1; end
      default: begin i_addr = addr; i_blk_read = 1'b1; end
    endcase
  endtask

  task automatic drop_all();
    i_blk_read = 1'b0; d_blk_read = 1'b0; d_blk_write = 1'b0;
  endtask

  // Called with the DUT idle; the next edge accepts the request.
  task automatic do_op(input string name, input int kind, input bit fast, input logic [31:0] addr,
                       input logic [255:0] wdata, input logic [255:0] exp_data, input int lat);
    int cyc;
    logic [2:0] exp_v;
    drive(kind, addr, wdata);
    wait_valid(kind, fast, cyc);
    chk({name, "_lat"}, 256'(cyc - 1), 256'(lat));
    exp_v = (kind == 0) ? 3'b001 : (kind == 1) ? 3'b010 : 3'b100;
    if (fast) chk({name, "_onehot"}, 256'({f_i_read_valid, f_d_read_valid, f_d_write_valid}), 256'(exp_v));
    else      chk({name, "_onehot"}, 256'({i_read_valid, d_read_valid, d_write_valid}), 256'(exp_v));
    if (kind != 0) chk({name, "_data"}, get_rdata(kind, fast), exp_data);
    drop_all();
    @(posedge CLK); #1;
    chk({name, "_pulse_end"}, 256'(get_valid(kind, fast)), 256'(0));
    chk({name, "_idle"}, 256'(fast ? f_busy : busy), 256'(0));
  endtask

  // I read and D read raised together; i_first selects which side must win.
  task automatic conflict(input string name, input bit i_first, input logic [31:0] ia,
                          input logic [255:0] iexp, input logic [31:0] da, input logic [255:0] dexp);
    int c1, c2;
    i_addr = ia; d_addr = da; i_blk_read = 1'b1; d_blk_read = 1'b1;
    wait_valid(i_first ? 2 : 1, 1'b0, c1);
    chk({name, "_first_lat"}, 256'(c1 - 1), 256'(10));
    chk({name, "_other_quiet"}, 256'(i_first ? d_read_valid : i_read_valid), 256'(0));
    chk({name, "_first_data"}, i_first ? i_rdata : d_rdata, i_first ? iexp : dexp);
    if (i_first) i_blk_read = 1'b0; else d_blk_read = 1'b0;
    wait_valid(i_first ? 1 : 2, 1'b0, c2);
    chk({name, "_gap"}, 256'(c2), 256'(12));
    chk({name, "_second_data"}, i_first ? d_rdata : i_rdata, i_first ? dexp : iexp);
    drop_all();
    @(posedge CLK); #1;
  endtask

  initial begin
    int cyc, c2, pulses, seen, nv;
    int vt[4];

    vecs[0] = '{"wr_A_40",   0, 32'h0000_0040, pat(32'hA000_0000), '0};
    vecs[1] = '{"rd_A_5C",   1, 32'h0000_005C, '0, pat(32'hA000_0000)};
    vecs[2] = '{"wr_B_8000", 0, 32'h0000_8000, pat(32'hB000_0000), '0};
    vecs[3] = '{"rd_B_0",    1, 32'h0000_0000, '0, pat(32'hB000_0000)};
    vecs[4] = '{"rd_B_1F",   1, 32'h0000_001F, '0, pat(32'hB000_0000)};
    vecs[5] = '{"ird_A_40",  2, 32'h0000_0040, '0, pat(32'hA000_0000)};
    vecs[6] = '{"wr_C_hi",   0, 32'h1234_5680, pat(32'hC000_0000), '0};
    vecs[7] = '{"ird_C",     2, 32'h0000_5690, '0, pat(32'hC000_0000)};

    RESET = 1'b1; i_addr = '0; d_addr = '0; d_wdata = '0;
    drop_all();
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_valids", 256'({i_read_valid, d_read_valid, d_write_valid}), 256'(0));
    chk("rst_i_rdata", i_rdata, '0);
    chk("rst_d_rdata", d_rdata, '0);
    RESET = 1'b0;
    @(posedge CLK); #1;
    chk("idle_busy", 256'(busy), 256'(0));

    for (int v = 0; v < 8; v++)
      do_op(vecs[v].name, vecs[v].kind, 1'b0, vecs[v].addr, vecs[v].wdata, vecs[v].exp_data, 10);

    // Fresh conflict: D wins in both builds.
    conflict("conf1", 1'b0, 32'h40, pat(32'hA000_0000), 32'h0, pat(32'hB000_0000));
    do_op("rd_D_solo", 1, 1'b0, 32'h5C, '0, pat(32'hA000_0000), 10);
`ifdef MEM_RR_ARB_EN
    conflict("conf2", 1'b1, 32'h40, pat(32'hA000_0000), 32'h0, pat(32'hB000_0000));
`else
    conflict("conf2", 1'b0, 32'h40, pat(32'hA000_0000), 32'h0, pat(32'hB000_0000));
`endif

    // D write and D read together: write first, pending read sees new data.
    d_addr = 32'h100; d_wdata = pat(32'hE000_0000); d_blk_write = 1'b1; d_blk_read = 1'b1;
    wait_valid(0, 1'b0, cyc);
    chk("wr_rd_write_lat", 256'(cyc - 1), 256'(10));
    chk("wr_rd_no_read_yet", 256'(d_read_valid), 256'(0));
    d_blk_write = 1'b0;
    wait_valid(1, 1'b0, c2);
    chk("wr_rd_read_gap", 256'(c2), 256'(12));
    chk("wr_rd_raw_data", d_rdata, pat(32'hE000_0000));
    drop_all();
    @(posedge CLK); #1;

    // Reset during cycle 5 of a write aborts it.
    drive(0, 32'h40, pat(32'h5A5A_0000));
    @(posedge CLK); #1;
    repeat (4) begin @(posedge CLK); #1; end
    chk("abort_busy_before", 256'(busy), 256'(1));
    RESET = 1'b1; drop_all();
    @(posedge CLK); #1;
    RESET = 1'b0;
    chk("abort_busy_after", 256'(busy), 256'(0));
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge CLK); #1;
      if (d_write_valid) pulses++;
    end
    chk("abort_no_wvalid", 256'(pulses), 256'(0));
    do_op("abort_readback", 1, 1'b0, 32'h40, '0, pat(32'hA000_0000), 10);

    // Requester holds d_blk_read one cycle past its valid pulse.
    d_addr = 32'h5C; d_blk_read = 1'b1;
    pulses = 0; seen = -1;
    for (int i = 0; i < 30; i++) begin
      @(posedge CLK); #1;
      if (d_read_valid) begin
        pulses++;
        if (seen < 0) seen = i;
      end
      if (seen >= 0 && i == seen + 1) d_blk_read = 1'b0;
    end
    chk("hold_single_valid", 256'(pulses), 256'(1));
    chk("hold_idle_after", 256'(busy), 256'(0));

    // Unit-latency instance.
    RESET = 1'b1; drop_all();
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(posedge CLK); #1;
    do_op("fast_wr", 0, 1'b1, 32'h60, pat(32'hD000_0000), '0, 1);
    do_op("fast_rd", 1, 1'b1, 32'h60, '0, pat(32'hD000_0000), 1);
    do_op("fast_ird", 2, 1'b1, 32'h60, '0, pat(32'hD000_0000), 1);

    i_addr = 32'h80; i_blk_read = 1'b1;
    nv = 0;
    for (int t = 0; t < 40 && nv < 4; t++) begin
      @(posedge CLK); #1;
      if (f_i_read_valid) begin
        vt[nv] = t;
        nv++;
        i_addr = i_addr + 32'h20;
      end
    end
    drop_all();
    chk("fast_stream_count", 256'(nv), 256'(4));
    for (int k = 1; k < 4; k++)
      chk($sformatf("fast_stream_gap%0d", k), 256'(k < nv ? vt[k] - vt[k-1] : -1), 256'(3));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
